// File: rtl/csr_file_if.sv
// CSR access port between the EX-stage privilege unit and csr_file.
// The requester drives address, strobes and data; the responder returns read data.
interface csr_file_if;
  logic [13:0] csr_addr;
  logic        csr_ren;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic [31:0] csr_wmask;
  logic [31:0] csr_rdata;

  modport master (
    output csr_addr, csr_ren, csr_wen,
    output csr_wdata, csr_wmask,
    input  csr_rdata
  );

  modport slave (
    input  csr_addr, csr_ren, csr_wen,
    input  csr_wdata, csr_wmask,
    output csr_rdata
  );
endinterface

// File: rtl/csr_file.sv
// LoongArch CSR file: CSR access port, exception/ERTN side effects,
// architectural timer and interrupt-pending logic.
module csr_file #(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  csr_file_if.slave   csr,
  input  logic        exc_valid,
  input  logic [5:0]  exc_ecode,
  input  logic [31:0] exc_pc,
  input  logic        exc_badv_we,
  input  logic [31:0] exc_badv,
  input  logic        ertn,
  input  logic [7:0]  hw_int,
  output logic [31:0] eentry_out,
  output logic [31:0] era_out,
  output logic [1:0]  plv_out,
  output logic        int_req
);
  localparam logic [13:0] A_CRMD   = 14'h000;
  localparam logic [13:0] A_PRMD   = 14'h001;
  localparam logic [13:0] A_ECFG   = 14'h004;
  localparam logic [13:0] A_ESTAT  = 14'h005;
  localparam logic [13:0] A_ERA    = 14'h006;
  localparam logic [13:0] A_BADV   = 14'h007;
  localparam logic [13:0] A_EENTRY = 14'h00C;
  localparam logic [13:0] A_SAVE0  = 14'h030;
  localparam logic [13:0] A_SAVE1  = 14'h031;
  localparam logic [13:0] A_SAVE2  = 14'h032;
  localparam logic [13:0] A_SAVE3  = 14'h033;
  localparam logic [13:0] A_TID    = 14'h040;
  localparam logic [13:0] A_TCFG   = 14'h041;
  localparam logic [13:0] A_TVAL   = 14'h042;
  localparam logic [13:0] A_TICLR  = 14'h044;

  logic [4:0]         crmd_q, crmd_d;
  logic [2:0]         prmd_q, prmd_d;
  logic [12:0]        ecfg_q, ecfg_d;
  logic [1:0]         is_sw_q, is_sw_d;
  logic [7:0]         is_hw_q;
  logic               ti_q, ti_d;
  logic [5:0]         ecode_q, ecode_d;
  logic [31:0]        era_q, era_d;
  logic [31:0]        badv_q, badv_d;
  logic [25:0]        eentry_q, eentry_d;
  logic [3:0][31:0]   save_q, save_d;
  logic [31:0]        tid_q, tid_d;
  logic [31:0]        tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;

  logic [12:0] is_all;
  logic [31:0] estat;
  logic [31:0] old;
  logic [31:0] nv;
  logic        wr;
  logic        tcfg_we;
  logic        ticlr;
  logic        tmr_set;

  assign is_all = {1'b0, ti_q, 1'b0, is_hw_q, is_sw_q};
  assign estat  = {10'b0, ecode_q, 3'b0, is_all};

  always_comb begin
    old = '0;
    unique case (csr.csr_addr)
      A_CRMD:   old = {27'b0, crmd_q};
      A_PRMD:   old = {29'b0, prmd_q};
      A_ECFG:   old = {19'b0, ecfg_q};
      A_ESTAT:  old = estat;
      A_ERA:    old = era_q;
      A_BADV:   old = badv_q;
      A_EENTRY: old = {eentry_q, 6'b0};
      A_SAVE0:  old = save_q[0];
      A_SAVE1:  old = save_q[1];
      A_SAVE2:  old = save_q[2];
      A_SAVE3:  old = save_q[3];
      A_TID:    old = tid_q;
      A_TCFG:   old = tcfg_q;
      A_TVAL:   old = tval_q;
      default:  old = '0;
    endcase
  end

  // Read returns the pre-write value so csrxchg sees the old contents.
  assign csr.csr_rdata = csr.csr_ren ? old : '0;
  assign nv      = (old & ~csr.csr_wmask) | (csr.csr_wdata & csr.csr_wmask);
  assign wr      = csr.csr_wen & ~exc_valid & ~ertn;
  assign tcfg_we = wr & (csr.csr_addr == A_TCFG);
  assign ticlr   = wr & (csr.csr_addr == A_TICLR) & nv[0];

  always_comb begin
    tval_d  = tval_q;
    tmr_set = 1'b0;
    if (tcfg_we) begin
      tval_d = {nv[31:2], 2'b00};
    end else if (tcfg_q[0]) begin
      if (tval_q != '0) begin
        tval_d  = tval_q - 1'b1;
        tmr_set = (tval_q == TIMER_W'(1));
      end else if (tcfg_q[1]) begin
        tval_d = {tcfg_q[31:2], 2'b00};
      end
    end
    ti_d = ti_q;
    if (ticlr)   ti_d = 1'b0;
    if (tmr_set) ti_d = 1'b1;
  end

  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    ecfg_d   = ecfg_q;
    is_sw_d  = is_sw_q;
    ecode_d  = ecode_q;
    era_d    = era_q;
    badv_d   = badv_q;
    eentry_d = eentry_q;
    save_d   = save_q;
    tid_d    = tid_q;
    tcfg_d   = tcfg_q;
    if (exc_valid) begin
      prmd_d        = crmd_q[2:0];
      crmd_d[2:0]   = 3'b000;
      ecode_d       = exc_ecode;
      era_d         = exc_pc;
      if (exc_badv_we) badv_d = exc_badv;
    end else if (ertn) begin
      crmd_d[2:0] = prmd_q;
    end else if (wr) begin
      unique case (csr.csr_addr)
        A_CRMD:   crmd_d    = nv[4:0];
        A_PRMD:   prmd_d    = nv[2:0];
        A_ECFG:   ecfg_d    = {nv[12:11], 1'b0, nv[9:0]};
        A_ESTAT:  is_sw_d   = nv[1:0];
        A_ERA:    era_d     = nv;
        A_BADV:   badv_d    = nv;
        A_EENTRY: eentry_d  = nv[31:6];
        A_SAVE0:  save_d[0] = nv;
        A_SAVE1:  save_d[1] = nv;
        A_SAVE2:  save_d[2] = nv;
        A_SAVE3:  save_d[3] = nv;
        A_TID:    tid_d     = nv;
        A_TCFG:   tcfg_d    = nv;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crmd_q   <= 5'b01000;
      prmd_q   <= '0;
      ecfg_q   <= '0;
      is_sw_q  <= '0;
      is_hw_q  <= '0;
      ti_q     <= 1'b0;
      ecode_q  <= '0;
      era_q    <= '0;
      badv_q   <= '0;
      eentry_q <= '0;
      save_q   <= '0;
      tid_q    <= '0;
      tcfg_q   <= '0;
      tval_q   <= '0;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      ecfg_q   <= ecfg_d;
      is_sw_q  <= is_sw_d;
      is_hw_q  <= hw_int;
      ti_q     <= ti_d;
      ecode_q  <= ecode_d;
      era_q    <= era_d;
      badv_q   <= badv_d;
      eentry_q <= eentry_d;
      save_q   <= save_d;
      tid_q    <= tid_d;
      tcfg_q   <= tcfg_d;
      tval_q   <= tval_d;
    end
  end

  assign eentry_out = {eentry_q, 6'b0};
  assign era_out    = era_q;
  assign plv_out    = crmd_q[1:0];
  assign int_req    = crmd_q[2] & |(is_all & ecfg_q);
endmodule

// File: tb/tb_csr_file.sv
// Randomized and directed bench for csr_file against an
// architectural CSR model.
module tb_csr_file;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  csr_file_if bus();
  logic        exc_valid, exc_badv_we, ertn, int_req;
  logic [5:0]  exc_ecode;
  logic [31:0] exc_pc, exc_badv, eentry_out, era_out;
  logic [7:0]  hw_int;
  logic [1:0]  plv_out;

  csr_file #(.TIMER_W(32)) dut (
    .clk(clk), .rst(rst), .csr(bus),
    .exc_valid(exc_valid), .exc_ecode(exc_ecode),
    .exc_pc(exc_pc), .exc_badv_we(exc_badv_we),
    .exc_badv(exc_badv), .ertn(ertn), .hw_int(hw_int),
    .eentry_out(eentry_out), .era_out(era_out),
    .plv_out(plv_out), .int_req(int_req)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  localparam bit [31:0] ONES = 32'hFFFF_FFFF;

  bit [31:0] m_crmd, m_prmd, m_ecfg, m_era, m_badv, m_eentry;
  bit [31:0] m_tid, m_tcfg, m_tval;
  bit [31:0] m_save [4];
  bit [1:0]  m_sw;
  bit [7:0]  m_hw;
  bit        m_ti;
  bit [5:0]  m_ecode;

  task automatic model_reset();
    m_crmd = 32'h8;
    m_prmd = 0; m_ecfg = 0; m_era = 0; m_badv = 0; m_eentry = 0;
    m_tid = 0; m_tcfg = 0; m_tval = 0;
    for (int i = 0; i < 4; i++) m_save[i] = 0;
    m_sw = 0; m_hw = 0; m_ti = 0; m_ecode = 0;
  endtask

  function automatic bit [31:0] m_estat();
    bit [31:0] e = 0;
    e[21:16] = m_ecode;
    e[11]    = m_ti;
    e[9:2]   = m_hw;
    e[1:0]   = m_sw;
    return e;
  endfunction

  function automatic bit [31:0] m_read(input bit [13:0] a);
    case (a)
      14'h00: return m_crmd;
      14'h01: return m_prmd;
      14'h04: return m_ecfg;
      14'h05: return m_estat();
      14'h06: return m_era;
      14'h07: return m_badv;
      14'h0C: return m_eentry;
      14'h30: return m_save[0];
      14'h31: return m_save[1];
      14'h32: return m_save[2];
      14'h33: return m_save[3];
      14'h40: return m_tid;
      14'h41: return m_tcfg;
      14'h42: return m_tval;
      default: return 0;
    endcase
  endfunction

  function automatic bit [31:0] wmask_of(input bit [13:0] a);
    case (a)
      14'h00: return 32'h1F;
      14'h01: return 32'h7;
      14'h04: return 32'h1BFF;
      14'h05: return 32'h3;
      14'h06, 14'h07, 14'h30, 14'h31, 14'h32, 14'h33,
      14'h40, 14'h41: return ONES;
      14'h0C: return 32'hFFFF_FFC0;
      default: return 0;
    endcase
  endfunction

  task automatic m_write(input bit [13:0] a, input bit [31:0] v);
    case (a)
      14'h00: m_crmd = v;
      14'h01: m_prmd = v;
      14'h04: m_ecfg = v;
      14'h05: m_sw = v[1:0];
      14'h06: m_era = v;
      14'h07: m_badv = v;
      14'h0C: m_eentry = v;
      14'h30: m_save[0] = v;
      14'h31: m_save[1] = v;
      14'h32: m_save[2] = v;
      14'h33: m_save[3] = v;
      14'h40: m_tid = v;
      14'h41: m_tcfg = v;
      default: ;
    endcase
  endtask

  function automatic bit exp_int();
    bit [31:0] e = m_estat();
    return m_crmd[2] && ((e[12:0] & m_ecfg[12:0]) != 0);
  endfunction

  task automatic model_step();
    bit [13:0] a = bus.csr_addr;
    bit [31:0] nv;
    bit wr, set_ti;
    wr = bus.csr_wen && !exc_valid && !ertn;
    nv = (m_read(a) & ~bus.csr_wmask) | (bus.csr_wdata & bus.csr_wmask);
    set_ti = 0;
    if (wr && a == 14'h41) begin
      m_tval = (nv >> 2) * 4;
    end else if (m_tcfg[0]) begin
      if (m_tval != 0) begin
        set_ti = (m_tval == 1);
        m_tval = m_tval - 1;
      end else if (m_tcfg[1]) begin
        m_tval = (m_tcfg >> 2) * 4;
      end
    end
    if (set_ti) m_ti = 1;
    else if (wr && a == 14'h44 && nv[0]) m_ti = 0;
    m_hw = hw_int;
    if (exc_valid) begin
      m_prmd  = m_crmd & 32'h7;
      m_crmd  = m_crmd & ~32'h7;
      m_ecode = exc_ecode;
      m_era   = exc_pc;
      if (exc_badv_we) m_badv = exc_badv;
    end else if (ertn) begin
      m_crmd = (m_crmd & ~32'h7) | m_prmd;
    end else if (wr) begin
      m_write(a, nv & wmask_of(a));
    end
  endtask

  task automatic tick();
    #1;
    if (bus.csr_ren) chk("rdata", bus.csr_rdata, m_read(bus.csr_addr));
    else chk("rdata_idle", bus.csr_rdata, 0);
    chk("int_req", int_req, exp_int());
    chk("plv_out", plv_out, m_crmd[1:0]);
    chk("era_out", era_out, m_era);
    chk("eentry_out", eentry_out, m_eentry);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.csr_ren = 0; bus.csr_wen = 0; bus.csr_addr = 0;
    bus.csr_wdata = 0; bus.csr_wmask = 0;
    exc_valid = 0; exc_ecode = 0; exc_pc = 0;
    exc_badv_we = 0; exc_badv = 0; ertn = 0;
  endtask

  task automatic op(input bit ren, input bit wen, input bit [13:0] a,
                    input bit [31:0] d, input bit [31:0] m);
    bus.csr_ren = ren; bus.csr_wen = wen; bus.csr_addr = a;
    bus.csr_wdata = d; bus.csr_wmask = m;
    tick();
    bus.csr_ren = 0; bus.csr_wen = 0;
  endtask

  task automatic rd(input string tag, input bit [13:0] a,
                    input bit [31:0] exp);
    bus.csr_ren = 1; bus.csr_addr = a;
    #1 chk(tag, bus.csr_rdata, exp);
    tick();
    bus.csr_ren = 0;
  endtask

  task automatic reset_and_check(input string tag);
    rst = 1;
    model_reset();
    idle();
    bus.csr_ren = 1;
    bus.csr_addr = 14'h00; #1 chk({tag, "_crmd"}, bus.csr_rdata, 32'h8);
    bus.csr_addr = 14'h05; #1 chk({tag, "_estat"}, bus.csr_rdata, 0);
    bus.csr_addr = 14'h42; #1 chk({tag, "_tval"}, bus.csr_rdata, 0);
    chk({tag, "_int"}, int_req, 0);
    chk({tag, "_plv"}, plv_out, 0);
    bus.csr_ren = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  bit [13:0] addrs [18] = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06,
    14'h07, 14'h0C, 14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41,
    14'h42, 14'h44, 14'h99, 14'h02, 14'h3FFF};

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bit [13:0] a = addrs[$urandom_range(0, 17)];
      bus.csr_addr  = a;
      bus.csr_ren   = $urandom_range(0, 1);
      bus.csr_wen   = ($urandom_range(0, 2) == 0);
      bus.csr_wdata = $urandom;
      bus.csr_wmask = $urandom_range(0, 1) ? ONES : $urandom;
      if (a == 14'h41) begin
        bus.csr_wdata = ($urandom_range(0, 5) << 2) | $urandom_range(0, 3);
        bus.csr_wmask = ONES;
      end
      exc_valid   = ($urandom_range(0, 19) == 0);
      ertn        = ($urandom_range(0, 19) == 0);
      exc_ecode   = $urandom;
      exc_pc      = $urandom;
      exc_badv_we = $urandom_range(0, 1);
      exc_badv    = $urandom;
      if ($urandom_range(0, 7) == 0) hw_int = $urandom;
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    hw_int = 0;
    #2;
    reset_and_check("reset");

    op(0, 1, 14'h30, 32'hFFFF_0000, ONES);
    bus.csr_ren = 1; bus.csr_wen = 1; bus.csr_addr = 14'h30;
    bus.csr_wdata = 32'h1234_5678; bus.csr_wmask = 32'h0000_FFFF;
    #1 chk("xchg_old", bus.csr_rdata, 32'hFFFF_0000);
    tick();
    idle();
    rd("xchg_new", 14'h30, 32'hFFFF_5678);

    op(0, 1, 14'h00, 32'h7, ONES);
    exc_valid = 1; exc_ecode = 6'h0B; exc_pc = 32'h1C00_0100;
    tick();
    idle();
    chk("exc_plv", plv_out, 0);
    rd("exc_crmd", 14'h00, 32'h0);
    rd("exc_prmd", 14'h01, 32'h7);
    rd("exc_era", 14'h06, 32'h1C00_0100);
    bus.csr_ren = 1; bus.csr_addr = 14'h05;
    #1 chk("exc_ecode", bus.csr_rdata[21:16], 6'h0B);
    tick();
    idle();
    ertn = 1;
    tick();
    ertn = 0;
    chk("ertn_plv", plv_out, 3);
    bus.csr_ren = 1; bus.csr_addr = 14'h00;
    #1 chk("ertn_ie", bus.csr_rdata[2], 1);
    tick();
    idle();

    reset_and_check("reset2");
    op(0, 1, 14'h04, 32'h800, ONES);
    op(0, 1, 14'h00, 32'h4, ONES);
    op(0, 1, 14'h41, 32'hB, ONES);
    for (int i = 0; i < 10; i++) begin
      bus.csr_ren = 1; bus.csr_addr = 14'h42;
      #1 chk("tval_seq", bus.csr_rdata, (i <= 8) ? 32'(8 - i) : 32'd8);
      chk("ti_seq", int_req, (i >= 8) ? 1 : 0);
      tick();
    end
    idle();
    bus.csr_wen = 1; bus.csr_addr = 14'h44;
    bus.csr_wdata = 1; bus.csr_wmask = ONES;
    #1 chk("ticlr_pre", int_req, 1);
    tick();
    idle();
    for (int v = 6; v >= 2; v--) begin
      bus.csr_ren = 1; bus.csr_addr = 14'h42;
      #1 chk("ticlr_tval", bus.csr_rdata, 32'(v));
      chk("ticlr_clr", int_req, 0);
      tick();
    end
    idle();
    bus.csr_wen = 1; bus.csr_addr = 14'h44;
    bus.csr_wdata = 1; bus.csr_wmask = ONES;
    tick();
    idle();
    bus.csr_ren = 1; bus.csr_addr = 14'h42;
    #1 chk("set_wins_tval", bus.csr_rdata, 0);
    chk("set_wins_ti", int_req, 1);
    tick();
    idle();

    reset_and_check("reset3");
    hw_int = 8'h01;
    op(0, 1, 14'h04, 32'h4, ONES);
    for (int i = 0; i < 2; i++) begin
      #1 chk("gate_ie0", int_req, 0);
      tick();
    end
    op(0, 1, 14'h00, 32'hC, ONES);
    #1 chk("gate_ie1", int_req, 1);
    tick();
    hw_int = 0;

    op(0, 1, 14'h31, 32'hA5A5_A5A5, ONES);
    bus.csr_wen = 1; bus.csr_addr = 14'h31;
    bus.csr_wdata = 32'h0; bus.csr_wmask = ONES;
    exc_valid = 1; exc_ecode = 6'h03; exc_pc = 32'h1C00_0200;
    tick();
    idle();
    rd("exc_drop_save1", 14'h31, 32'hA5A5_A5A5);
    op(0, 1, 14'h99, 32'hDEAD_BEEF, ONES);
    rd("unimpl_99", 14'h99, 32'h0);

    rand_cycles(800);
    reset_and_check("reset_mid");
    rand_cycles(1200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
